// File: rtl/tetris_field_store.sv
// tetris_field_store
// Holds the Tetris playfield bitmap, FIELD_W columns by FIELD_H rows, one bit
// per cell. The VGA scanner reads it combinationally. Game logic queues row
// writes and clear requests. Those updates are applied only inside a commit
// window that opens after the scanner's end-of-frame pulse, so the visible
// field never changes mid-frame.
//
// Ports:
//   vga_clk, rst_n     pixel clock; asynchronous active-low reset
//   x_coord, y_coord   scanner cell column / row
//   coord_value        cell state at (x_coord, y_coord); 0 when out of range
//   draw_finish        end-of-frame pulse that opens a commit window
//   wr_valid/wr_ready  row-write handshake into the FIFO
//   wr_row, wr_data    target row and contents (bit i = column i)
//   clr_req            request to zero the field in the next window
//   window_open        high while clearing or draining
//   commit_done        one-cycle pulse when a window closes
//   pending_count      FIFO occupancy
module tetris_field_store #(
    parameter int FIELD_W       = 10,
    parameter int FIELD_H       = 20,
    parameter int FIFO_DEPTH    = 4,
    parameter int WINDOW_CYCLES = 1600
) (
    input  logic               vga_clk,
    input  logic               rst_n,
    input  logic [7:0]         x_coord,
    input  logic [7:0]         y_coord,
    output logic               coord_value,
    input  logic               draw_finish,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [4:0]         wr_row,
    input  logic [FIELD_W-1:0] wr_data,
    input  logic               clr_req,
    output logic               window_open,
    output logic               commit_done,
    output logic [2:0]         pending_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int COL_W = $clog2(FIELD_W);
    localparam int ROW_W = $clog2(FIELD_H);

    localparam logic [2:0]       DEPTH_C  = 3'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic               clear_pending_q, clear_pending_d;

    // Row-write FIFO
    logic [4:0]         fifo_row_q  [FIFO_DEPTH];
    logic [FIELD_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [2:0]         count_q, count_d;
    logic               push, pop;
    logic [4:0]         head_row;
    logic [FIELD_W-1:0] head_data;

    logic [FIELD_W-1:0] grid_rows [FIELD_H];

    assign wr_ready      = (count_q != DEPTH_C);
    assign push          = wr_valid && wr_ready;
    assign pop           = (state_q == ST_DRAIN) && (count_q != 3'd0);
    assign head_row      = fifo_row_q[rd_ptr_q];
    assign head_data     = fifo_data_q[rd_ptr_q];
    assign pending_count = count_q;
    assign window_open   = (state_q == ST_CLEAR) || (state_q == ST_DRAIN);
    assign commit_done   = (state_q == ST_DONE);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage carries no reset; only the pointers and count matter.
    always_ff @(posedge vga_clk) begin
        if (push) begin
            fifo_row_q[wr_ptr_q]  <= wr_row;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    // A clear request arriving in the CLEAR cycle itself must survive to the
    // next window, so the set term has priority over the consume term.
    assign clear_pending_d = clr_req | (clear_pending_q & (state_q != ST_CLEAR));

    // The counter is loaded with WINDOW_CYCLES-1 and counts window cycles
    // down; a DRAIN cycle that sees it already at zero is the last cycle of
    // the window, which keeps the window at most WINDOW_CYCLES cycles long.
    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (draw_finish) begin
                    win_cnt_d = WIN_LOAD;
                    state_d   = clear_pending_q ? ST_CLEAR : ST_DRAIN;
                end
            end
            ST_CLEAR: begin
                if (win_cnt_q != '0) win_cnt_d = win_cnt_q - CNT_ONE;
                state_d = (win_cnt_q == '0) ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (win_cnt_q != '0) win_cnt_d = win_cnt_q - CNT_ONE;
                if (!pop || (win_cnt_q == '0)) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            win_cnt_q       <= '0;
            clear_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            win_cnt_q       <= win_cnt_d;
            clear_pending_q <= clear_pending_d;
        end
    end

    // One register per row. A popped entry whose row index is out of range
    // matches no row and is simply dropped.
    genvar gi;
    generate
        for (gi = 0; gi < FIELD_H; gi++) begin : g_row
            logic [FIELD_W-1:0] row_q;
            always_ff @(posedge vga_clk or negedge rst_n) begin
                if (!rst_n) begin
                    row_q <= '0;
                end else if (state_q == ST_CLEAR) begin
                    row_q <= '0;
                end else if (pop && (head_row == 5'(gi))) begin
                    row_q <= head_data;
                end
            end
            assign grid_rows[gi] = row_q;
        end
    endgenerate

    always_comb begin
        coord_value = 1'b0;
        if ((x_coord < 8'(FIELD_W)) && (y_coord < 8'(FIELD_H))) begin
            coord_value = grid_rows[y_coord[ROW_W-1:0]][x_coord[COL_W-1:0]];
        end
    end
endmodule

// File: tb/tb_tetris_field_store.sv
module tb_tetris_field_store;
    localparam int W  = 10;
    localparam int H  = 20;
    localparam int NI = 2;

    logic         vga_clk = 1'b0;
    logic         rst_n;
    logic [7:0]   x_coord, y_coord;
    logic         draw_finish, wr_valid, clr_req;
    logic [4:0]   wr_row;
    logic [W-1:0] wr_data;

    logic [NI-1:0] coord_value_o, wr_ready_o, window_open_o, commit_done_o;
    logic [2:0]    pend_o [NI];

    // Instance 0 has a long window; instance 1 has a two-cycle window.
    tetris_field_store #(.FIELD_W(W), .FIELD_H(H), .FIFO_DEPTH(4), .WINDOW_CYCLES(1600)) dut_a (
        .vga_clk(vga_clk), .rst_n(rst_n), .x_coord(x_coord), .y_coord(y_coord),
        .coord_value(coord_value_o[0]), .draw_finish(draw_finish), .wr_valid(wr_valid),
        .wr_ready(wr_ready_o[0]), .wr_row(wr_row), .wr_data(wr_data), .clr_req(clr_req),
        .window_open(window_open_o[0]), .commit_done(commit_done_o[0]), .pending_count(pend_o[0])
    );
    tetris_field_store #(.FIELD_W(W), .FIELD_H(H), .FIFO_DEPTH(4), .WINDOW_CYCLES(2)) dut_b (
        .vga_clk(vga_clk), .rst_n(rst_n), .x_coord(x_coord), .y_coord(y_coord),
        .coord_value(coord_value_o[1]), .draw_finish(draw_finish), .wr_valid(wr_valid),
        .wr_ready(wr_ready_o[1]), .wr_row(wr_row), .wr_data(wr_data), .clr_req(clr_req),
        .window_open(window_open_o[1]), .commit_done(commit_done_o[1]), .pending_count(pend_o[1])
    );

    always #5 vga_clk = ~vga_clk;

    // Reference model: field contents, queued entries as an ordered list,
    // and the clear flag, one set per instance.
    logic [W-1:0] m_grid [NI][H];
    logic [4:0]   m_qrow [NI][4];
    logic [W-1:0] m_qdat [NI][4];
    int           m_len  [NI];
    bit           m_clr  [NI];

    int n_cmp = 0;
    int n_err = 0;

    function automatic int win_of(input int i);
        return (i == 0) ? 1600 : 2;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int r = 0; r < H; r++) m_grid[i][r] = '0;
            m_len[i] = 0;
            m_clr[i] = 1'b0;
        end
    endtask

    task automatic check_grid();
        for (int y = 0; y <= H; y++) begin
            for (int x = 0; x <= W; x++) begin
                x_coord = 8'(x);
                y_coord = 8'(y);
                #1;
                for (int i = 0; i < NI; i++)
                    check_eq($sformatf("cv%0d(x%0d,y%0d)", i, x, y), coord_value_o[i],
                             (x < W && y < H) ? m_grid[i][y][x] : 1'b0);
            end
        end
        for (int k = 0; k < 4; k++) begin
            x_coord = 8'($urandom_range(0, 255));
            y_coord = 8'($urandom_range(20, 255));
            #1;
            for (int i = 0; i < NI; i++)
                check_eq($sformatf("cv%0d_oob(x%0d,y%0d)", i, x_coord, y_coord), coord_value_o[i], 0);
        end
        @(negedge vga_clk);
    endtask

    task automatic push_row(input logic [4:0] row, input logic [W-1:0] data);
        for (int i = 0; i < NI; i++)
            check_eq($sformatf("wr_ready%0d_pre", i), wr_ready_o[i], m_len[i] < 4);
        wr_valid = 1'b1;
        wr_row   = row;
        wr_data  = data;
        @(negedge vga_clk);
        wr_valid = 1'b0;
        for (int i = 0; i < NI; i++) begin
            if (m_len[i] < 4) begin
                m_qrow[i][m_len[i]] = row;
                m_qdat[i][m_len[i]] = data;
                m_len[i]++;
            end
            check_eq($sformatf("pending%0d_push", i), pend_o[i], m_len[i]);
        end
        $display("push row=%0d data=%03h queued=%0d/%0d", row, data, m_len[0], m_len[1]);
    endtask

    task automatic req_clear();
        clr_req = 1'b1;
        @(negedge vga_clk);
        clr_req = 1'b0;
        for (int i = 0; i < NI; i++) m_clr[i] = 1'b1;
        $display("clear request");
    endtask

    // One commit window. Expected window length, pop timing and final field
    // are derived from the queue contents and window budget.
    task automatic run_frame(input bit extra_df, input bit probe, input int px, input int py);
        int n0 [NI];
        int c0 [NI];
        int pops [NI];
        int len [NI];
        int lmax;
        int d;
        int popped;
        lmax = 0;
        for (int i = 0; i < NI; i++) begin
            c0[i]   = m_clr[i] ? 1 : 0;
            n0[i]   = m_len[i];
            d       = win_of(i) - c0[i];
            pops[i] = (n0[i] < d) ? n0[i] : d;
            len[i]  = c0[i] + ((n0[i] < d) ? n0[i] + 1 : d);
            if (len[i] > lmax) lmax = len[i];
            if (m_clr[i]) for (int r = 0; r < H; r++) m_grid[i][r] = '0;
            for (int k = 0; k < pops[i]; k++)
                if (m_qrow[i][k] < 5'(H)) m_grid[i][m_qrow[i][k]] = m_qdat[i][k];
            for (int k = 0; k < n0[i] - pops[i]; k++) begin
                m_qrow[i][k] = m_qrow[i][k + pops[i]];
                m_qdat[i][k] = m_qdat[i][k + pops[i]];
            end
            m_len[i] = n0[i] - pops[i];
            m_clr[i] = 1'b0;
        end
        draw_finish = 1'b1;
        @(negedge vga_clk);
        draw_finish = 1'b0;
        for (int j = 1; j <= lmax + 3; j++) begin
            for (int i = 0; i < NI; i++) begin
                popped = j - 1 - c0[i];
                if (popped < 0) popped = 0;
                if (popped > pops[i]) popped = pops[i];
                check_eq($sformatf("window_open%0d_c%0d", i, j), window_open_o[i], j <= len[i]);
                check_eq($sformatf("commit_done%0d_c%0d", i, j), commit_done_o[i], j == len[i] + 1);
                check_eq($sformatf("pending%0d_c%0d", i, j), pend_o[i], n0[i] - popped);
                check_eq($sformatf("wr_ready%0d_c%0d", i, j), wr_ready_o[i], (n0[i] - popped) != 4);
            end
            if (probe && j == 2) begin
                x_coord = 8'(px);
                y_coord = 8'(py);
                #1;
                check_eq("probe_first_pop", coord_value_o[0], m_grid[0][py][px]);
            end
            draw_finish = extra_df && (j == 2);
            @(negedge vga_clk);
        end
        draw_finish = 1'b0;
        $display("frame pops=%0d/%0d window=%0d/%0d extra_df=%0d", pops[0], pops[1], len[0], len[1], extra_df);
        check_grid();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; x_coord = '0; y_coord = '0; draw_finish = 1'b0;
        wr_valid = 1'b0; clr_req = 1'b0; wr_row = '0; wr_data = '0;
        model_reset();
        repeat (3) @(negedge vga_clk);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("rst_wr_ready%0d", i), wr_ready_o[i], 1);
            check_eq($sformatf("rst_window%0d", i), window_open_o[i], 0);
            check_eq($sformatf("rst_done%0d", i), commit_done_o[i], 0);
            check_eq($sformatf("rst_pending%0d", i), pend_o[i], 0);
        end
        rst_n = 1'b1;
        @(negedge vga_clk);
        $display("reset released");
        check_grid();

        // Single row write, visible only after the window commits it.
        push_row(5'd3, 10'b0000000101);
        check_grid();
        run_frame(1'b0, 1'b1, 0, 3);

        // Fill the FIFO, try a fifth push, then drain.
        push_row(5'd1, 10'h155);
        push_row(5'd2, 10'h2AA);
        push_row(5'd4, 10'h0F0);
        push_row(5'd5, 10'h30F);
        push_row(5'd6, 10'h3FF);
        run_frame(1'b0, 1'b0, 0, 0);
        run_frame(1'b0, 1'b0, 0, 0);

        // Clear followed by a write to the last row.
        push_row(5'd7, 10'h111);
        run_frame(1'b0, 1'b0, 0, 0);
        req_clear();
        push_row(5'd19, 10'h3FF);
        run_frame(1'b0, 1'b0, 0, 0);
        run_frame(1'b0, 1'b0, 0, 0);

        // Out-of-range row is discarded.
        push_row(5'd25, 10'h3FF);
        push_row(5'd0, 10'h3FF);
        run_frame(1'b0, 1'b0, 0, 0);

        // Short-window instance commits in pieces; draw_finish mid-window ignored.
        push_row(5'd8, 10'h001);
        push_row(5'd9, 10'h002);
        push_row(5'd8, 10'h004);
        push_row(5'd10, 10'h008);
        run_frame(1'b1, 1'b0, 0, 0);
        run_frame(1'b1, 1'b0, 0, 0);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 5)
                push_row(($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, H - 1)) : 5'($urandom_range(0, 31)),
                         10'($urandom));
            else if (op == 6)
                req_clear();
            else
                run_frame(1'($urandom_range(0, 1)), 1'b0, 0, 0);
        end

        // Reset in the middle of a drain.
        push_row(5'd11, 10'h3FF);
        push_row(5'd12, 10'h3FF);
        push_row(5'd13, 10'h3FF);
        draw_finish = 1'b1;
        @(negedge vga_clk);
        draw_finish = 1'b0;
        @(negedge vga_clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("midrst_window%0d", i), window_open_o[i], 0);
            check_eq($sformatf("midrst_pending%0d", i), pend_o[i], 0);
            check_eq($sformatf("midrst_wr_ready%0d", i), wr_ready_o[i], 1);
        end
        $display("reset asserted mid-window");
        check_grid();
        rst_n = 1'b1;
        @(negedge vga_clk);
        run_frame(1'b0, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
